// File: rtl/cic_pkg.sv
// Shared widths and helpers for the CIC interpolator.
package cic_pkg;

   // Reference configuration of the interpolator.
   localparam int I_WIDTH_DEFAULT     = 16;
   localparam int ORDER_DEFAULT       = 3;
   localparam int INTERP_BITS_DEFAULT = 4;
   localparam int R                   = 2 ** INTERP_BITS_DEFAULT;

   // Full-precision output width: gain of the chain is R^(N-1).
   function automatic int cic_int_width(input int i_width, input int order, input int interp_bits);
      return i_width + (order - 1) * interp_bits;
   endfunction

   // Ceiling log2 for small positive integers.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

   // Comb stage j needs one extra bit per differentiation to stay exact.
   function automatic int comb_width(input int i_width, input int j);
      return i_width + j;
   endfunction

endpackage

// File: rtl/cic_int_stage.sv
// One integrator of the interpolator: wrapping accumulator, no saturation.
module cic_int_stage #(
   parameter int W = 24
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_en,
   input  logic signed [W-1:0] i_x,
   output logic signed [W-1:0] o_acc
);

   logic signed [W-1:0] acc_reg;

   // Accumulate the previous stage's registered value on every enabled cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         acc_reg <= '0;
      end else if (i_en) begin
         acc_reg <= acc_reg + i_x;
      end
   end

   assign o_acc = acc_reg;

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator: sample-rate combs, zero stuffing, full-rate integrators.
module cic_interpolator
   import cic_pkg::*;
#(
   parameter int I_WIDTH     = 16,
   parameter int ORDER       = 3,
   parameter int INTERP_BITS = 4,
   parameter int O_WIDTH     = cic_int_width(I_WIDTH, ORDER, INTERP_BITS)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_en,
   input  logic signed [I_WIDTH-1:0] i_data,
   output logic                      o_strobe,
   output logic                      o_clk,
   output logic signed [O_WIDTH-1:0] o_data
);

   // Widest comb stage; every comb value is carried sign-extended to this width.
   localparam int CMAX = comb_width(I_WIDTH, ORDER);

   logic [INTERP_BITS-1:0]    cnt_reg;
   logic                      o_clk_reg;
   logic                      strobe;
   logic signed [CMAX-1:0]    c [0:ORDER];
   logic signed [O_WIDTH-1:0] z_reg;
   logic signed [O_WIDTH-1:0] acc [0:ORDER];

   // A strobe marks phase 0 of each frame; it is suppressed while in reset.
   assign strobe   = i_en & (cnt_reg == '0) & ~i_rst;
   assign o_strobe = strobe;
   assign o_clk    = o_clk_reg;

   // Phase counter and low-rate clock; cnt < R/2 is exactly "top bit clear".
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_reg   <= '0;
         o_clk_reg <= 1'b0;
      end else if (i_en) begin
         cnt_reg   <= cnt_reg + 1'b1;
         o_clk_reg <= ~cnt_reg[INTERP_BITS-1];
      end
   end

   assign c[0] = CMAX'(i_data);

   generate
      for (genvar gi = 1; gi <= ORDER; gi++) begin : g_comb
         localparam int W = comb_width(I_WIDTH, gi);
         logic signed [W-1:0] prev;
         logic signed [W-1:0] d_reg;
         logic signed [W-1:0] diff;

         // Previous stage fits in W-1 bits, so its low W bits are its sign extension.
         assign prev = c[gi-1][W-1:0];
         assign diff = prev - d_reg;
         assign c[gi] = CMAX'(diff);

         // Comb delay (M = 1) advances only when a new low-rate sample is taken.
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               d_reg <= '0;
            end else if (strobe) begin
               d_reg <= prev;
            end
         end
      end
   endgenerate

   // Zero stuffing: comb output on the strobe cycle, zero on the other R-1.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         z_reg <= '0;
      end else if (i_en) begin
         z_reg <= strobe ? O_WIDTH'(c[ORDER]) : '0;
      end
   end

   assign acc[0] = z_reg;

   generate
      for (genvar gi = 1; gi <= ORDER; gi++) begin : g_int
         cic_int_stage #(
            .W (O_WIDTH)
         ) u_int (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_en  (i_en),
            .i_x   (acc[gi-1]),
            .o_acc (acc[gi])
         );
      end
   endgenerate

   assign o_data = acc[ORDER];

endmodule

// File: tb/tb_cic_interpolator.sv
// Bench for cic_interpolator: FIR-equivalent model (upsample, then boxcar^N).
module tb_cic_interpolator;

   localparam int IW  = 16;
   localparam int N   = 3;
   localparam int IB  = 4;
   localparam int RR  = 16;
   localparam int OW  = 24;
   localparam int HL  = N * (RR - 1) + 1;
   localparam int XSZ = 8192;

   logic                 clk;
   logic                 rst;
   logic                 en;
   logic signed [IW-1:0] data;
   logic                 strobe;
   logic                 oclk;
   logic signed [OW-1:0] odata;

   int checks   = 0;
   int failures = 0;

   longint h [0:HL-1];
   longint x [0:XSZ-1];
   int     e = 0;

   bit     acc_on = 0;
   longint acc_sum = 0;
   int     acc_nz = 0;
   longint first_vals [0:4];
   bit     win_on = 0;
   int     win_strobes = 0;
   int     win_clk_hi = 0;

   cic_interpolator #(
      .I_WIDTH     (IW),
      .ORDER       (N),
      .INTERP_BITS (IB)
   ) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_en     (en),
      .i_data   (data),
      .o_strobe (strobe),
      .o_clk    (oclk),
      .o_data   (odata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint req);
      checks = checks + 1;
      if (act != req) begin
         failures = failures + 1;
         if (failures <= 30)
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Expected output after e enabled edges: upsampled input convolved with h, delayed N.
   function automatic logic [OW-1:0] model_y(input int ecount);
      longint s;
      int     idx;
      s = 0;
      for (int k = 0; k < HL; k++) begin
         idx = ecount - N - k;
         if (idx >= 1) s = s + h[k] * x[idx];
      end
      return s[OW-1:0];
   endfunction

   // Model: record the zero-stuffed input stream, one entry per enabled edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         e = 0;
      end else if (en) begin
         if ((e % RR) == 0) begin
            x[e+1] = longint'(data);
            $display("sample edge=%0d data=%0d", e + 1, data);
         end else begin
            x[e+1] = 0;
         end
         e = e + 1;
      end
   end

   // Compare DUT against the model every cycle, mid-period.
   always @(negedge clk) begin
      logic [OW-1:0] ey;
      bit es;
      bit ec;
      ey = model_y(e);
      es = en && !rst && ((e % RR) == 0);
      ec = (e == 0) ? 1'b0 : (((e - 1) % RR) < RR / 2);
      check("o_data_vs_model", longint'(odata), longint'($signed(ey)));
      check("o_strobe_vs_model", longint'(strobe), longint'(es));
      check("o_clk_vs_model", longint'(oclk), longint'(ec));
      if (acc_on) begin
         acc_sum = acc_sum + longint'(odata);
         if (odata != 0) begin
            if (acc_nz < 5) first_vals[acc_nz] = longint'(odata);
            acc_nz = acc_nz + 1;
         end
      end
      if (win_on) begin
         if (strobe) win_strobes = win_strobes + 1;
         if (oclk) win_clk_hi = win_clk_hi + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run n enabled cycles; the strobe cycle gets sample, the rest get garbage.
   task automatic cycles(input int sample, input int n);
      for (int i = 0; i < n; i++) begin
         data = ((e % RR) == 0) ? IW'(sample) : IW'($urandom);
         tick();
      end
   endtask

   initial begin
      longint hs;
      longint tmp [0:HL-1];
      int     len;
      int     nzh;

      // Impulse response of the chain: three length-R boxcars convolved.
      for (int i = 0; i < HL; i++) h[i] = 0;
      h[0] = 1;
      len = 1;
      for (int s = 0; s < N; s++) begin
         for (int i = 0; i < HL; i++) tmp[i] = 0;
         for (int i = 0; i < len; i++)
            for (int j = 0; j < RR; j++) tmp[i+j] = tmp[i+j] + h[i];
         len = len + RR - 1;
         for (int i = 0; i < HL; i++) h[i] = tmp[i];
      end
      hs = 0;
      nzh = 0;
      for (int i = 0; i < HL; i++) begin
         hs = hs + h[i];
         if (h[i] != 0) nzh = nzh + 1;
      end
      check("model_h0", h[0], 1);
      check("model_h1", h[1], 3);
      check("model_h4", h[4], 15);
      check("model_hsum", hs, 4096);
      check("model_hlen", nzh, 46);

      rst  = 1'b1;
      en   = 1'b0;
      data = '0;
      repeat (3) tick();
      check("reset_o_data", longint'(odata), 0);
      check("reset_o_clk", longint'(oclk), 0);
      check("reset_o_strobe", longint'(strobe), 0);
      rst = 1'b0;
      en  = 1'b1;

      win_on = 1;
      cycles(0, 64);
      win_on = 0;
      check("strobe_count_64", win_strobes, 4);
      check("o_clk_high_64", win_clk_hi, 32);

      acc_on = 1;
      cycles(1, 16);
      cycles(0, 96);
      acc_on = 0;
      check("impulse_sum", acc_sum, 4096);
      check("impulse_nonzero", acc_nz, 46);
      check("impulse_v0", first_vals[0], 1);
      check("impulse_v1", first_vals[1], 3);
      check("impulse_v2", first_vals[2], 6);
      check("impulse_v3", first_vals[3], 10);
      check("impulse_v4", first_vals[4], 15);
      check("impulse_tail", longint'(odata), 0);

      cycles(1, 80);
      check("step_1", longint'(odata), 256);
      cycles(32767, 80);
      check("step_max", longint'(odata), 32'sh007FFF00);
      cycles(-32768, 80);
      check("step_min", longint'(odata), -8388608);

      cycles(0, 80);
      cycles(100, 7);
      en = 1'b0;
      repeat (5) tick();
      en = 1'b1;
      cycles(100, 80);
      check("step_after_hold", longint'(odata), 25600);

      cycles(0, 80);
      cycles(1, 16);
      cycles(0, 8);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_o_data", longint'(odata), 0);
      check("async_rst_o_strobe", longint'(strobe), 0);
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("first_strobe_after_rst", longint'(strobe), 1);
      tick();
      cycles(1, 16);
      cycles(0, 64);
      check("post_rst_tail", longint'(odata), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cic_interpolator.md
Name: cic_interpolator

Overview:
- Cascaded integrator-comb interpolator: the transmit-side counterpart of the team's pruned CIC decimator.
- Takes low-rate signed samples, upsamples by R = 2^INTERP_BITS, and produces full-rate signed output.
- Output feeds the sigma-delta modulator / DAC path of iCESDM.
- Comb section runs at the sample rate; integrator section runs every enabled i_clk cycle.

Parameters:
- I_WIDTH, 16: input sample width, signed two's complement.
- ORDER, 3: number of comb stages (N) and number of integrator stages (N); legal range 2..6.
- INTERP_BITS, 4: log2 of interpolation ratio R; legal range 2..8.
- O_WIDTH, I_WIDTH+(ORDER-1)*INTERP_BITS: full-precision output width (derived, do not override).

Ports:
- i_clk  in  1  high-rate clock; sole clock of the block.
- i_rst  in  1  reset, asynchronous and active-high; clears all state.
- i_en  in  1  clock enable; when low, all state holds.
- i_data  in  I_WIDTH  signed low-rate sample, sampled on strobe cycles only.
- o_strobe  out  1  high for exactly one enabled cycle per R, when i_data is consumed.
- o_clk  out  1  low-rate clock, 50% duty, period R cycles.
- o_data  out  O_WIDTH  signed interpolated output, one value per enabled cycle.

Behaviour:
- Reset values: phase counter cnt = 0; all comb delay registers, zero-stuff register z, and integrators = 0; o_data = 0; o_strobe = 0; o_clk = 0.
- Reset is asynchronous on assertion; the first enabled cycle after release is a strobe cycle (cnt = 0).
- Phase counter: cnt is INTERP_BITS wide and increments by 1 on each enabled cycle, wrapping R-1 -> 0.
- o_strobe = i_en & (cnt == 0) & ~i_rst. It is combinational from the registered cnt.
- o_clk = registered bit, 1 while cnt < R/2, else 0. It is low during reset.
- Upstream handshake:
  - Producer holds i_data valid whenever o_strobe can be high.
  - The block samples i_data only on cycles where o_strobe = 1.
  - No backpressure; ignored i_data values have no effect.
- Comb section, evaluated on strobe cycles only:
  - c0 = i_data.
  - cj = c(j-1) - dj, for j = 1..N.
  - On the strobe edge, dj <= c(j-1).
  - Stage j width is I_WIDTH+j, with sign extension on each subtract.
  - Differential delay M = 1.
- Zero stuffing:
  - On every enabled edge, z <= o_strobe ? cN : 0.
  - z is sign-extended to O_WIDTH.
- Integrators:
  - On every enabled edge, int1 <= int1 + z and intk <= intk + int(k-1), for k = 2..N.
  - All integrators are O_WIDTH wide; two's-complement wrap is intended and must not be saturated.
  - O_WIDTH >= I_WIDTH+N is guaranteed by the parameter limits.
- o_data = intN (a register).
- Latency: an impulse sampled on the strobe edge at cycle t0 first appears as nonzero o_data after N+1 enabled edges, counting from t0 inclusive.
- DC gain: constant input K gives a steady-state o_data of K*R^(N-1), exact with no truncation.
- i_en low mid-frame: cnt, o_clk, combs, z and integrators all freeze; o_strobe = 0; o_data holds. Resuming continues from the same phase.
- i_rst mid-frame clears everything at once. Output restarts from 0, with a strobe on the first enabled cycle after release.
- Full-scale input (-2^(I_WIDTH-1)) reaches exactly -2^(O_WIDTH-1) in steady state with no overflow.

Decomposition:
- Package cic_pkg holds:
  - function cic_int_width(I_WIDTH, ORDER, INTERP_BITS);
  - function clog2;
  - localparam R;
  - per-stage comb width function comb_width(j) = I_WIDTH+j.
- One natural sub-module: cic_int_stage (parameter W; inputs i_clk, i_rst, i_en, i_x; output o_acc), instantiated N times by a generate loop.
- Combs stay inline in a generate loop.

Test Plan (I_WIDTH = 16, ORDER = 3, INTERP_BITS = 4, R = 16, O_WIDTH = 24):
- Reset, then release with i_en = 1: o_data = 0, o_strobe pulses every 16 cycles starting at the first cycle, o_clk high for 8 cycles and low for 8.
- Impulse (i_data = 1 for one strobe, 0 otherwise): o_data sequence starting N+1 edges after the strobe is 1, 3, 6, 10, 15, ...; 46 nonzero samples; sum = 4096; returns to 0 and stays there.
- Step to i_data = 1: o_data settles to 256 (0x000100) after 3 strobe periods.
- Step to i_data = 32767: settles to 0x7FFF00. Then step to -32768: settles to 0x800000 with no spurious wrap in the settled value.
- i_en toggled low for 5 cycles mid-frame during a step: o_data and o_clk hold. The strobe spacing counts enabled cycles only. The final response is identical to the uninterrupted run, delayed by 5 cycles.
- i_rst asserted asynchronously (between clock edges) mid-impulse-response: o_data = 0 immediately. After release, the first strobe occurs on the first cycle.
